nts_tx_buffer: RTL and testbench
================================

# nts_tx_buffer

Transmit-side packet buffer for the NTS engine: the mirror of the receive path. Engine-side logic writes one response packet as 64-bit words; the block then presents it to the transmit dispatcher through the same packet-available / FIFO-read / read-discard handshake the receive dispatcher offers the engine. Holds exactly one packet at a time.

## Interface
- ADDR_WIDTH, 10, log2 of capacity in 64-bit words (1024 words).
- i_clk  in  1  clock.
- i_reset_n  in  1  reset. **Synchronous, active-low.**
- i_clear  in  1  synchronous abort. Forces EMPTY.
- i_wr_en  in  1  write strobe for one word.
- i_wr_data  in  64  word to write. First wire byte is in [63:56].
- i_wr_last  in  1  qualifies i_wr_en: this is the final word.
- i_wr_last_dv  in  8  byte-valid mask of the final word. Sampled with i_wr_last.
- o_busy  out  1  high when writes are not accepted (state ≠ EMPTY, WRITE).
- o_error  out  1  sticky overflow flag. Cleared only by reset or i_clear.
- o_packet_available  out  1  a complete packet is held.
- o_data_valid  out  8  last-word byte mask while o_packet_available, else 0.
- o_fifo_empty  out  1  no unread words remain.
- i_fifo_rd_en  in  1  read request.
- o_fifo_rd_data  out  64  read word.
- i_packet_read_discard  in  1  release the packet.

## Operation
- **States:** EMPTY, WRITE, AVAILABLE, ERROR.
- **EMPTY:**
  - i_wr_en stores the word at wr_ptr=0 and increments wr_ptr.
  - If i_wr_last is also high, latch i_wr_last_dv and word_count=1, then go to AVAILABLE.
  - Otherwise go to WRITE.
- **WRITE:**
  - Each i_wr_en stores at wr_ptr and increments it.
  - i_wr_last latches word_count=wr_ptr+1 and the mask, then goes to AVAILABLE.
- **Overflow:** a write in WRITE when wr_ptr has wrapped to 0 (2^ADDR_WIDTH words already stored) goes to ERROR.
  - The word is not stored.
  - o_error=1 and o_busy=1.
  - ERROR is left only via i_clear or reset.
- **Widths:**
  - wr_ptr and rd_ptr are ADDR_WIDTH bits.
  - word_count is ADDR_WIDTH+1 bits, so a full buffer of 2^ADDR_WIDTH words is legal.
- **AVAILABLE:**
  - o_packet_available=1 and o_data_valid=latched mask.
  - o_fifo_empty = (rd_count == word_count).
  - i_fifo_rd_en with !o_fifo_empty reads RAM[rd_ptr] and increments rd_ptr/rd_count.
  - i_fifo_rd_en while o_fifo_empty is ignored; o_fifo_rd_data holds its value.
  - i_wr_en is ignored (o_busy=1).
- **i_packet_read_discard:**
  - In AVAILABLE it goes to EMPTY and zeroes the pointers and mask.
  - It is legal before all words are read (early discard).
  - It is ignored in the other states.
- **Priority:** reset > i_clear > discard > rd_en/wr_en.
  - Discard and rd_en in the same cycle: the read is not performed.
- **Mask:** passed through unchecked. 8'hFF means the full word is valid; 8'h80 means only [63:56] is valid.

## Timing
- **Reset values:**
  - o_busy=0, o_error=0, o_packet_available=0, o_data_valid=0.
  - o_fifo_empty=1, o_fifo_rd_data=0, state=EMPTY.
- **Writes:** one word per cycle, accepted on the edge where i_wr_en is sampled high.
  - o_packet_available and o_busy rise the cycle after the last-word edge.
- **Read latency:** o_fifo_rd_data is valid the cycle after the accepting rd_en edge and holds until the next accepted read.
  - rd_en may be asserted every cycle.
  - o_fifo_empty rises the cycle after the edge that accepts the final word.
- **Discard:** o_packet_available, o_busy and o_data_valid fall the cycle after the discard edge; o_fifo_empty=1 in that same cycle.
  - A new write is accepted on the following edge.
- **i_clear / reset mid-packet:** the next cycle shows reset values.
  - Partially written or read data is lost.
  - o_fifo_rd_data clears to 0.

## Structure
- State encodings and the full-mask constant (8'hFF) go in the shared NTS defines package.
- One sub-module, nts_tx_ram: simple dual-port, 2^ADDR_WIDTH × 64, one write port, registered read port with 1-cycle latency.
- The FSM, pointers, counters and flags live in nts_tx_buffer.

## Test plan
- **Basic packet:**
  - Stimulus: write 3 words (0x1111…, 0x2222…, 0x3333…) with last on word 3 and mask 8'hF0.
  - Required response: available=1 and data_valid=8'hF0 the next cycle. Three back-to-back rd_en return the words in order at 1-cycle latency. empty=1 after the third. Discard gives available=0 and busy=0 next cycle.
- **Single-word packet:**
  - Stimulus: wr_en+last in EMPTY with mask 8'h80.
  - Required response: word_count=1. One read returns the word. A second rd_en leaves data unchanged and empty=1.
- **Full and overflow:**
  - Stimulus: ADDR_WIDTH=4; write 16 words with last on the 16th.
  - Required response: available=1 and all 16 read back.
  - Stimulus: repeat with 17 writes and no last.
  - Required response: error=1 and busy=1; clear returns error=0.
- **Early discard:**
  - Stimulus: read 1 of 5 words, then assert discard together with rd_en.
  - Required response: no read is performed; EMPTY next cycle. A new 2-word packet then reads back correctly from address 0.
- **Writes while busy:**
  - Stimulus: wr_en in AVAILABLE.
  - Required response: ignored; the read-back matches the original packet.
- **Mid-packet reset:**
  - Stimulus: i_reset_n=0 for one cycle during WRITE, and again during reads.
  - Required response: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/nts_tx_buffer_pkg.sv
// Shared NTS defines for the transmit buffer: FSM encoding and mask constants.
package nts_tx_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WRITE = 2'd1,
    ST_AVAIL = 2'd2,
    ST_ERROR = 2'd3
  } tx_state_e;

  localparam logic [7:0] DV_FULL = 8'hFF;

endpackage

// File: rtl/nts_tx_ram.sv
// Simple dual-port packet RAM, 2^ADDR_WIDTH x 64, registered read (1-cycle latency).
module nts_tx_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [63:0]           i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [63:0]           o_rd_data
);

  logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [63:0] rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // No reset on the read register so it maps onto block RAM output regs.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) rd_data_q <= mem[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/nts_tx_buffer.sv
// Single-packet transmit buffer: engine writes a packet, dispatcher reads it out.
module nts_tx_buffer
  import nts_tx_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear,
  input  logic        i_wr_en,
  input  logic [63:0] i_wr_data,
  input  logic        i_wr_last,
  input  logic [7:0]  i_wr_last_dv,
  output logic        o_busy,
  output logic        o_error,
  output logic        o_packet_available,
  output logic [7:0]  o_data_valid,
  output logic        o_fifo_empty,
  input  logic        i_fifo_rd_en,
  output logic [63:0] o_fifo_rd_data,
  input  logic        i_packet_read_discard
);

  tx_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_count_q, rd_count_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [7:0]            dv_q, dv_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  wr_go, rd_go, discard, fifo_empty;
  logic [63:0]           ram_rd_data;

  // In WRITE, wr_ptr back at 0 means the whole RAM is already filled.
  assign wr_go      = i_wr_en && !i_clear &&
                      (state_q == ST_EMPTY || (state_q == ST_WRITE && wr_ptr_q != '0));
  assign discard    = i_packet_read_discard && !i_clear && state_q == ST_AVAIL;
  assign fifo_empty = (state_q != ST_AVAIL) || (rd_count_q == word_count_q);
  assign rd_go      = i_fifo_rd_en && !i_clear && !discard && !fifo_empty;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= ST_EMPTY;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (i_wr_en) state_d = i_wr_last ? ST_AVAIL : ST_WRITE;
        ST_WRITE: if (i_wr_en) begin
          if (wr_ptr_q == '0)  state_d = ST_ERROR;
          else if (i_wr_last) state_d = ST_AVAIL;
        end
        ST_AVAIL: if (discard) state_d = ST_EMPTY;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_busy             = (state_q == ST_AVAIL) || (state_q == ST_ERROR);
    o_error            = (state_q == ST_ERROR);
    o_packet_available = (state_q == ST_AVAIL);
    o_data_valid       = (state_q == ST_AVAIL) ? dv_q : 8'h00;
    o_fifo_empty       = fifo_empty;
    o_fifo_rd_data     = rd_vld_q ? ram_rd_data : 64'h0;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_count_d   = rd_count_q;
    word_count_d = word_count_q;
    dv_d         = dv_q;
    rd_vld_d     = rd_vld_q;
    if (i_clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rd_count_d   = '0;
      word_count_d = '0;
      dv_d         = '0;
      rd_vld_d     = 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_wr_last) begin
          word_count_d = {1'b0, wr_ptr_q} + 1'b1;
          dv_d         = i_wr_last_dv;
        end
      end
      if (discard) begin
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        rd_count_d   = '0;
        word_count_d = '0;
        dv_d         = '0;
      end
      if (rd_go) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_count_d = rd_count_q + 1'b1;
        rd_vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_count_q   <= '0;
      word_count_q <= '0;
      dv_q         <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_count_q   <= rd_count_d;
      word_count_q <= word_count_d;
      dv_q         <= dv_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  nts_tx_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_go && i_reset_n),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_en   (rd_go && i_reset_n),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_nts_tx_buffer.sv
// Directed bench for nts_tx_buffer with a 16-word RAM.
module tb_nts_tx_buffer;
  import nts_tx_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, clear, wr_en, wr_last, rd_en, discard;
  logic [63:0] wr_data;
  logic [7:0]  wr_last_dv;
  logic        busy, error, avail, empty;
  logic [7:0]  dv;
  logic [63:0] rd_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  nts_tx_buffer #(.ADDR_WIDTH(4)) dut (
    .i_clk                 (clk),
    .i_reset_n             (reset_n),
    .i_clear               (clear),
    .i_wr_en               (wr_en),
    .i_wr_data             (wr_data),
    .i_wr_last             (wr_last),
    .i_wr_last_dv          (wr_last_dv),
    .o_busy                (busy),
    .o_error               (error),
    .o_packet_available    (avail),
    .o_data_valid          (dv),
    .o_fifo_empty          (empty),
    .i_fifo_rd_en          (rd_en),
    .o_fifo_rd_data        (rd_data),
    .i_packet_read_discard (discard)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"},  64'(busy),    64'd0);
    chk({tag, ".error"}, 64'(error),   64'd0);
    chk({tag, ".avail"}, 64'(avail),   64'd0);
    chk({tag, ".dv"},    64'(dv),      64'd0);
    chk({tag, ".empty"}, 64'(empty),   64'd1);
    chk({tag, ".data"},  rd_data,      64'd0);
  endtask

  task automatic wr(input logic [63:0] d, input logic last, input logic [7:0] m);
    wr_en = 1'b1; wr_data = d; wr_last = last; wr_last_dv = m;
    step();
    wr_en = 1'b0; wr_last = 1'b0; wr_last_dv = 8'h00;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    discard = 1'b0; wr_data = '0; wr_last_dv = '0;
    step(); step();
    chk_reset("reset");
    reset_n = 1'b1;
    step();

    // basic 3-word packet
    wr(64'h1111_1111_1111_1111, 1'b0, 8'h00);
    chk("basic.busy_in_write", 64'(busy), 64'd0);
    wr(64'h2222_2222_2222_2222, 1'b0, 8'h00);
    wr(64'h3333_3333_3333_3333, 1'b1, 8'hF0);
    chk("basic.avail", 64'(avail), 64'd1);
    chk("basic.dv",    64'(dv),    64'hF0);
    chk("basic.busy",  64'(busy),  64'd1);
    chk("basic.empty0", 64'(empty), 64'd0);
    rd_en = 1'b1;
    step(); chk("basic.rd0", rd_data, 64'h1111_1111_1111_1111);
    step(); chk("basic.rd1", rd_data, 64'h2222_2222_2222_2222);
    chk("basic.empty_mid", 64'(empty), 64'd0);
    step(); chk("basic.rd2", rd_data, 64'h3333_3333_3333_3333);
    chk("basic.empty_end", 64'(empty), 64'd1);
    rd_en = 1'b0;
    discard = 1'b1; step(); discard = 1'b0;
    chk("basic.disc_avail", 64'(avail), 64'd0);
    chk("basic.disc_busy",  64'(busy),  64'd0);
    chk("basic.disc_dv",    64'(dv),    64'd0);
    chk("basic.disc_empty", 64'(empty), 64'd1);

    // single-word packet
    wr(64'hDEAD_BEEF_0000_0001, 1'b1, 8'h80);
    chk("single.avail", 64'(avail), 64'd1);
    chk("single.dv",    64'(dv),    64'h80);
    chk("single.empty0", 64'(empty), 64'd0);
    rd_en = 1'b1;
    step(); chk("single.rd", rd_data, 64'hDEAD_BEEF_0000_0001);
    chk("single.empty1", 64'(empty), 64'd1);
    step(); chk("single.rd_hold", rd_data, 64'hDEAD_BEEF_0000_0001);
    chk("single.empty2", 64'(empty), 64'd1);
    rd_en = 1'b0;
    discard = 1'b1; step(); discard = 1'b0;

    // writes while AVAILABLE are dropped
    wr(64'hAAAA_0000_0000_000A, 1'b0, 8'h00);
    wr(64'hBBBB_0000_0000_000B, 1'b1, 8'hFF);
    wr(64'hCCCC_0000_0000_000C, 1'b1, 8'h01);
    chk("busywr.busy", 64'(busy), 64'd1);
    chk("busywr.dv",   64'(dv),   64'hFF);
    rd_en = 1'b1;
    step(); chk("busywr.rd0", rd_data, 64'hAAAA_0000_0000_000A);
    step(); chk("busywr.rd1", rd_data, 64'hBBBB_0000_0000_000B);
    chk("busywr.empty", 64'(empty), 64'd1);
    rd_en = 1'b0;
    discard = 1'b1; step(); discard = 1'b0;

    // full buffer: 16 words, last on 16th
    for (int k = 0; k < 16; k++)
      wr({8{8'(k + 8'h40)}}, k == 15, DV_FULL);
    chk("full.avail", 64'(avail), 64'd1);
    chk("full.error", 64'(error), 64'd0);
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("full.rd%0d", k), rd_data, {8{8'(k + 8'h40)}});
    end
    chk("full.empty", 64'(empty), 64'd1);
    rd_en = 1'b0;
    discard = 1'b1; step(); discard = 1'b0;

    // overflow: 17 writes without last
    for (int k = 0; k < 16; k++) wr(64'(k), 1'b0, 8'h00);
    chk("ovf.no_err_yet", 64'(error), 64'd0);
    chk("ovf.busy_yet",   64'(busy),  64'd0);
    wr(64'hFFFF, 1'b0, 8'h00);
    chk("ovf.error", 64'(error), 64'd1);
    chk("ovf.busy",  64'(busy),  64'd1);
    chk("ovf.avail", 64'(avail), 64'd0);
    clear = 1'b1; step(); clear = 1'b0;
    chk_reset("ovf.clear");

    // early discard together with rd_en
    for (int k = 0; k < 5; k++)
      wr(64'hE0 + 64'(k), k == 4, 8'h0F);
    rd_en = 1'b1;
    step(); chk("early.rd0", rd_data, 64'hE0);
    discard = 1'b1; step(); discard = 1'b0; rd_en = 1'b0;
    chk("early.avail", 64'(avail), 64'd0);
    chk("early.busy",  64'(busy),  64'd0);
    chk("early.empty", 64'(empty), 64'd1);
    chk("early.no_read", rd_data, 64'hE0);
    wr(64'hF0F0_0000_0000_0000, 1'b0, 8'h00);
    wr(64'hF1F1_0000_0000_0001, 1'b1, 8'hC0);
    chk("early.dv2", 64'(dv), 64'hC0);
    rd_en = 1'b1;
    step(); chk("early.new0", rd_data, 64'hF0F0_0000_0000_0000);
    step(); chk("early.new1", rd_data, 64'hF1F1_0000_0000_0001);
    rd_en = 1'b0;
    discard = 1'b1; step(); discard = 1'b0;

    // reset during WRITE
    wr(64'h5555, 1'b0, 8'h00);
    wr(64'h6666, 1'b0, 8'h00);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk_reset("rst_write");

    // reset during reads
    wr(64'h7777, 1'b0, 8'h00);
    wr(64'h8888, 1'b1, 8'hFF);
    rd_en = 1'b1;
    step(); chk("rst_read.rd0", rd_data, 64'h7777);
    rd_en = 1'b0;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk_reset("rst_read");

    // buffer usable again after reset
    wr(64'h9999, 1'b1, 8'h80);
    rd_en = 1'b1;
    step(); chk("post_rst.rd", rd_data, 64'h9999);
    rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
